// File: rtl/uart_arb_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_arb_pkg
// Purpose  : Shared definitions for the UART transmit arbiter: byte width,
//            default header base and the FSM state encoding.
// Config   : UART_ARB_HEADER_EN adds the S_HDR state (per-packet header).
// Revision : 1.0 - initial release
// ============================================================================
package uart_arb_pkg;

    localparam int              c_BYTE_W      = 8;
    localparam logic [7:0]      c_HEADER_BASE = 8'hA0;
    localparam int              c_STATE_W     = 3;

    typedef enum logic [c_STATE_W-1:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_KICK = 3'd2,
        S_GAP  = 3'd3,
`ifdef UART_ARB_HEADER_EN
        S_WAIT = 3'd4,
        S_HDR  = 3'd5
`else
        S_WAIT = 3'd4
`endif
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin pick: first asserted request at or
//            after the pointer, modulo NUM_REQ.
// Ports    : req   - request vector
//            ptr   - round-robin start index (held by the parent)
//            found - at least one request asserted
//            idx   - index of the selected request (valid when found)
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic               found,
    output logic [ID_W-1:0]    idx
);

    logic [NUM_REQ-1:0] w_rot;
    logic [ID_W-1:0]    w_off;
    logic [ID_W:0]      w_sum;

    // Rotate so that bit 0 is the request at the pointer position.
    assign w_rot = NUM_REQ'({req, req} >> ptr);

    // Descending scan: the lowest offset written last wins.
    always_comb begin
        found = 1'b0;
        w_off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                found = 1'b1;
                w_off = ID_W'(k);
            end
        end
    end

    // Map the offset back to an absolute index, wrapping past NUM_REQ-1.
    assign w_sum = {1'b0, ptr} + {1'b0, w_off};
    assign idx   = (w_sum >= (ID_W+1)'(NUM_REQ)) ? ID_W'(w_sum - (ID_W+1)'(NUM_REQ))
                                                 : w_sum[ID_W-1:0];

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Shares one uart_tx serializer between NUM_REQ byte streams with
//            packet-granular round-robin. The owner keeps the UART until its
//            last-flagged byte has left the wire. One start pulse per byte.
// Ports    : clk, rst            - clock, synchronous active-high reset
//                                  (uart_tx is reset by the same signal)
//            req_valid/data/last - per-requester byte stream
//            req_ready           - one-hot, only the owner in S_LOAD
//            uart_start/data     - byte handoff to uart_tx
//            uart_finish         - uart_tx done/idle
//            busy, grant_id      - status; grant_id valid while busy
// Config   : `define UART_ARB_HEADER_EN sends HEADER_BASE|id before each packet
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int                  NUM_REQ     = 4,
    parameter int                  ID_W        = 2,
    parameter logic [c_BYTE_W-1:0] HEADER_BASE = c_HEADER_BASE
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [c_BYTE_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]          req_last,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        uart_start,
    output logic [c_BYTE_W-1:0]         uart_data,
    input  logic                        uart_finish,
    output logic                        busy,
    output logic [ID_W-1:0]             grant_id
);

    state_t              r_state;
    logic [ID_W-1:0]     r_grant_id;
    logic [ID_W-1:0]     r_ptr;
    logic                r_last;
    logic                r_uart_start;
    logic [c_BYTE_W-1:0] r_uart_data;

    logic [c_BYTE_W-1:0] w_bytes [NUM_REQ];
    logic                w_found;
    logic [ID_W-1:0]     w_idx;
    logic [ID_W-1:0]     w_ptr_next;
    logic [NUM_REQ-1:0]  w_req_ready;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign w_bytes[i] = req_data[c_BYTE_W*i +: c_BYTE_W];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .req   (req_valid),
        .ptr   (r_ptr),
        .found (w_found),
        .idx   (w_idx)
    );

    assign w_ptr_next = (r_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : r_grant_id + ID_W'(1);

    always_comb begin
        w_req_ready = '0;
        if (r_state == S_LOAD) begin
            w_req_ready[r_grant_id] = 1'b1;
        end
    end

`ifndef UART_ARB_HEADER_EN
    // The header base only matters when headers are enabled.
    logic w_unused_hdr;
    assign w_unused_hdr = ^HEADER_BASE;
`endif

    // uart_start is raised on the transition into S_KICK, so it is high for
    // exactly the S_KICK cycle and is cleared by the default below.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_grant_id   <= '0;
            r_ptr        <= '0;
            r_last       <= 1'b0;
            r_uart_start <= 1'b0;
            r_uart_data  <= '0;
        end else begin
            r_uart_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant_id <= w_idx;
`ifdef UART_ARB_HEADER_EN
                        r_state    <= S_HDR;
`else
                        r_state    <= S_LOAD;
`endif
                    end
                end
`ifdef UART_ARB_HEADER_EN
                S_HDR: begin
                    // Header is never the end of a packet, so S_WAIT returns to S_LOAD.
                    r_uart_data  <= HEADER_BASE | c_BYTE_W'(r_grant_id);
                    r_last       <= 1'b0;
                    r_uart_start <= 1'b1;
                    r_state      <= S_KICK;
                end
`endif
                S_LOAD: begin
                    if (req_valid[r_grant_id]) begin
                        r_uart_data  <= w_bytes[r_grant_id];
                        r_last       <= req_last[r_grant_id];
                        r_uart_start <= 1'b1;
                        r_state      <= S_KICK;
                    end
                end
                S_KICK: r_state <= S_GAP;
                // uart_tx drops finish only one cycle after start, so it is
                // not trusted here.
                S_GAP:  r_state <= S_WAIT;
                S_WAIT: begin
                    if (uart_finish) begin
                        if (r_last) begin
                            r_ptr   <= w_ptr_next;
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_LOAD;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = w_req_ready;
    assign uart_start = r_uart_start;
    assign uart_data  = r_uart_data;
    assign busy       = (r_state != S_IDLE);
    assign grant_id   = r_grant_id;

endmodule
`default_nettype wire
